timer_mmio_ctrl: RTL



---
 rtl/timer_mmio_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/timer_mmio_ctrl.sv
// Command sequencer mastering the timer's MMIO bus: turns CONFIG, LOAD and
// READ commands into register write/read sequences and returns one response.
module timer_mmio_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3FF5_0000,
    parameter int          UPD_WAIT  = 2,
    parameter int          TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [63:0] cmd_data,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_wr,
    output logic        bus_rd,
    input  logic        bus_rd_valid,
    input  logic [31:0] bus_rdata
);

    localparam logic [31:0] A_CFG    = BASE_ADDR + 32'h0000_F000;
    localparam logic [31:0] A_LO     = BASE_ADDR + 32'h0000_F004;
    localparam logic [31:0] A_HI     = BASE_ADDR + 32'h0000_F008;
    localparam logic [31:0] A_UPD    = BASE_ADDR + 32'h0000_F00C;
    localparam logic [31:0] A_LOADLO = BASE_ADDR + 32'h0000_F018;
    localparam logic [31:0] A_LOADHI = BASE_ADDR + 32'h0000_F01C;
    localparam logic [31:0] A_LOAD   = BASE_ADDR + 32'h0000_F020;

    localparam logic [3:0] UW_LAST = 4'(UPD_WAIT - 1);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, W_CFG, W_LLO, W_LHI, W_LD, W_UPD,
        UPD_WT, R_LO, WT_LO, R_HI, WT_HI, RSP
    } state_t;

    state_t      state;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [3:0]  wcnt;
    logic [7:0]  tcnt;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            wcnt      <= '0;
            tcnt      <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wr    <= 1'b0;
            bus_rd    <= 1'b0;
        end else begin
            bus_wr    <= 1'b0;
            bus_rd    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        hi_q <= cmd_data[63:32];
                        unique case (cmd_op)
                            2'd0: begin
                                state     <= W_CFG;
                                bus_wr    <= 1'b1;
                                bus_addr  <= A_CFG;
                                bus_wdata <= cmd_data[31:0];
                            end
                            2'd1: begin
                                state     <= W_LLO;
                                bus_wr    <= 1'b1;
                                bus_addr  <= A_LOADLO;
                                bus_wdata <= cmd_data[31:0];
                            end
                            2'd2: begin
                                state     <= W_UPD;
                                bus_wr    <= 1'b1;
                                bus_addr  <= A_UPD;
                                bus_wdata <= '0;
                            end
                            default: begin
                                state     <= RSP;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                                rsp_data  <= '0;
                            end
                        endcase
                    end
                end
                W_CFG, W_LD: begin
                    state     <= RSP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= '0;
                end
                W_LLO: begin
                    state     <= W_LHI;
                    bus_wr    <= 1'b1;
                    bus_addr  <= A_LOADHI;
                    bus_wdata <= hi_q;
                end
                W_LHI: begin
                    state     <= W_LD;
                    bus_wr    <= 1'b1;
                    bus_addr  <= A_LOAD;
                    bus_wdata <= '0;
                end
                W_UPD: begin
                    state <= UPD_WT;
                    wcnt  <= '0;
                end
                UPD_WT: begin
                    if (wcnt == UW_LAST) begin
                        state     <= R_LO;
                        bus_rd    <= 1'b1;
                        bus_addr  <= A_LO;
                        bus_wdata <= '0;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                R_LO: begin
                    state <= WT_LO;
                    tcnt  <= '0;
                end
                R_HI: begin
                    state <= WT_HI;
                    tcnt  <= '0;
                end
                // a valid arriving on the last allowed cycle still wins
                WT_LO, WT_HI: begin
                    if (bus_rd_valid) begin
                        if (state == WT_LO) begin
                            lo_q     <= bus_rdata;
                            state    <= R_HI;
                            bus_rd   <= 1'b1;
                            bus_addr <= A_HI;
                        end else begin
                            state     <= RSP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= {bus_rdata, lo_q};
                        end
                    end else if (tcnt == TO_LAST) begin
                        tcnt      <= tcnt + 8'd1;
                        state     <= RSP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                RSP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
